// File: rtl/mirror_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mirror_pkg : constants and types shared by the mirror SPI link
// Rev 1.0
// ------------------------------------------------------------------
package mirror_pkg;

    localparam logic [7:0] START_BYTE   = 8'hFF;
    localparam logic [7:0] END_BYTE     = 8'hFE;
    localparam int         MAX_COL      = 40;
    localparam int         MAX_ROW      = 15;
    localparam int         PACKET_BYTES = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } tx_state_t;

    function automatic logic [7:0] packet_byte(
        input logic [2:0] idx,
        input logic [7:0] c,
        input logic [7:0] r,
        input logic [7:0] ch
    );
        case (idx)
            3'd0:    packet_byte = START_BYTE;
            3'd1:    packet_byte = c;
            3'd2:    packet_byte = r;
            3'd3:    packet_byte = ch;
            default: packet_byte = END_BYTE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mirror_spi_frame_tx_shifter.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_byte_shifter : mode-0 serializer for one byte, MSB first
// Rev 1.0
// ------------------------------------------------------------------
module spi_byte_shifter #(
    parameter int CLK_DIV = 64
) (
    input  logic       master_clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] byte_in,
    input  logic       enable,
    output logic       s_clk,
    output logic       mosi,
    output logic       byte_done
);

    localparam int HCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HCW-1:0] HALF_LAST = HCW'(CLK_DIV - 1);

    logic [HCW-1:0] half_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           phase;
    logic           hold;
    logic           active;
    logic           half_end;

    assign half_end = (half_cnt == HALF_LAST);

    // The load cycle is the first low cycle of bit 7, so the count restarts at 1.
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            half_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            phase    <= 1'b0;
            hold     <= 1'b0;
            active   <= 1'b0;
        end else if (load) begin
            half_cnt <= HCW'(1);
            bit_cnt  <= 3'd7;
            shreg    <= byte_in;
            phase    <= 1'b0;
            hold     <= 1'b0;
            active   <= 1'b1;
        end else if (enable && active) begin
            if (half_end) begin
                half_cnt <= '0;
                if (hold) begin
                    hold   <= 1'b0;
                    active <= 1'b0;
                end else if (phase) begin
                    phase <= 1'b0;
                    if (bit_cnt == 3'd0) begin
                        hold <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                        shreg   <= {shreg[6:0], 1'b0};
                    end
                end else begin
                    phase <= 1'b1;
                end
            end else begin
                half_cnt <= half_cnt + 1'b1;
            end
        end
    end

    assign s_clk     = phase;
    assign mosi      = load ? byte_in[7] : (active & shreg[7]);
    assign byte_done = enable & active & hold & half_end;

endmodule
`default_nettype wire

// File: rtl/mirror_spi_frame_tx.sv
`default_nettype none
// ------------------------------------------------------------------
// mirror_spi_frame_tx : writes one character cell to the mirror over SPI
// Rev 1.0
// ------------------------------------------------------------------
module mirror_spi_frame_tx
    import mirror_pkg::*;
#(
    parameter int CLK_DIV    = 64,
    parameter int GAP_CYCLES = 16
) (
    input  logic       master_clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] col,
    input  logic [7:0] row,
    input  logic [7:0] char_in,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic       s_clk,
    output logic       ss,
    output logic       mosi
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX = 3'(PACKET_BYTES - 1);

    tx_state_t     state;
    tx_state_t     state_next;
    logic [2:0]    byte_idx;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    hold_col;
    logic [7:0]    hold_row;
    logic [7:0]    hold_char;
    logic          done_q;
    logic          err_q;
    logic          range_ok;
    logic          accept;
    logic          gap_end;
    logic          last_byte;
    logic          sh_load;
    logic          sh_enable;
    logic          byte_done;
    logic [7:0]    cur_byte;

    assign range_ok  = (col < 8'(MAX_COL)) && (row < 8'(MAX_ROW));
    assign accept    = (state == IDLE) && start && range_ok;
    assign gap_end   = (gap_cnt == GAP_LAST);
    assign last_byte = (byte_idx == LAST_IDX);
    assign cur_byte  = packet_byte(byte_idx, hold_col, hold_row, hold_char);

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (byte_done) state_next = GAP;
            GAP:     if (gap_end) state_next = last_byte ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == IDLE);
        ss        = !((state == LOAD) || (state == SHIFT));
        sh_load   = (state == LOAD);
        sh_enable = (state == SHIFT);
    end

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            byte_idx  <= 3'd0;
            gap_cnt   <= '0;
            hold_col  <= 8'd0;
            hold_row  <= 8'd0;
            hold_char <= 8'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= (state == GAP) && gap_end && last_byte;
            err_q  <= (state == IDLE) && start && !range_ok;
            if (accept) begin
                hold_col  <= col;
                hold_row  <= row;
                hold_char <= char_in;
                byte_idx  <= 3'd0;
            end else if ((state == GAP) && gap_end && !last_byte) begin
                byte_idx <= byte_idx + 3'd1;
            end
            if (state == GAP) gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
            else              gap_cnt <= '0;
        end
    end

    assign done = done_q;
    assign err  = err_q;

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .master_clk (master_clk),
        .reset      (reset),
        .load       (sh_load),
        .byte_in    (cur_byte),
        .enable     (sh_enable),
        .s_clk      (s_clk),
        .mosi       (mosi),
        .byte_done  (byte_done)
    );

endmodule
`default_nettype wire
